// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the data-memory access stage: FSM states, operation
// codes and the latency counter type.
package mem_ctrl_pkg;

  localparam int CNT_W = 4;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_ISSUE = 2'b01;
  localparam logic [1:0] ST_WAIT  = 2'b10;
  localparam logic [1:0] ST_DONE  = 2'b11;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  typedef logic [CNT_W-1:0] lat_cnt_t;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Processor-side request/response and memory-side bus of the access stage.
// The master side is whoever issues requests and also models the data memory.
interface mem_access_ctrl_if #(
  parameter int WIDTH = 16
);

  logic             start;
  logic             op_we;
  logic [WIDTH-1:0] addr_in;
  logic [WIDTH-1:0] wdata_in;
  logic             busy;
  logic             done;
  logic             reg_wr;
  logic [WIDTH-1:0] rdata_out;
  logic             mem_en;
  logic             mem_we;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem_rdata;

  modport master (
    output start, op_we, addr_in, wdata_in, mem_rdata,
    input  busy, done, reg_wr, rdata_out, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  start, op_we, addr_in, wdata_in, mem_rdata,
    output busy, done, reg_wr, rdata_out, mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/lat_counter.sv
// Down-counter timing the memory read latency; flags the cycle in which the
// count is 1 so the next edge both reaches 0 and captures the read data.
module lat_counter
  import mem_ctrl_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     load,
  input  lat_cnt_t val,
  output logic     zero_next
);

  lat_cnt_t count;

  // NOTE: state registers use non-blocking assignments with the async reset
  // in the sensitivity list, so every flop updates on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= val;
    end else if (count != '0) begin
      count <= count - lat_cnt_t'(1);
    end
  end

  assign zero_next = (count == lat_cnt_t'(1));

endmodule

// File: rtl/mem_access_ctrl.sv
// Sequenced single read/write to a fixed-latency synchronous data memory,
// returning read data with a one-cycle destination-register write strobe.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int MEM_LAT = 2
) (
  input logic               clk,
  input logic               rst_n,
  mem_access_ctrl_if.slave  bus
);

  logic [1:0]       state;
  logic             op_we_q;
  logic             cnt_load;
  logic             zero_next;

  logic             busy_q;
  logic             done_q;
  logic             reg_wr_q;
  logic             mem_en_q;
  logic             mem_we_q;
  logic [WIDTH-1:0] mem_addr_q;
  logic [WIDTH-1:0] mem_wdata_q;
  logic [WIDTH-1:0] rdata_q;

  // The counter is armed in the ISSUE cycle so WAIT lasts exactly MEM_LAT cycles.
  assign cnt_load = (state == ST_ISSUE) && (op_we_q == OP_READ);

  lat_counter u_lat_counter (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (cnt_load),
    .val       (lat_cnt_t'(MEM_LAT)),
    .zero_next (zero_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      op_we_q     <= OP_READ;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      reg_wr_q    <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      done_q   <= 1'b0;
      reg_wr_q <= 1'b0;
      mem_en_q <= 1'b0;
      mem_we_q <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            state      <= ST_ISSUE;
            busy_q     <= 1'b1;
            op_we_q    <= bus.op_we;
            mem_en_q   <= 1'b1;
            mem_we_q   <= bus.op_we;
            mem_addr_q <= bus.addr_in;
            if (bus.op_we == OP_WRITE) begin
              mem_wdata_q <= bus.wdata_in;
            end
          end
        end

        ST_ISSUE: begin
          if (op_we_q == OP_WRITE) begin
            state  <= ST_DONE;
            done_q <= 1'b1;
          end else begin
            state <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (zero_next) begin
            state    <= ST_DONE;
            rdata_q  <= bus.mem_rdata;
            done_q   <= 1'b1;
            reg_wr_q <= 1'b1;
          end
        end

        ST_DONE: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.reg_wr    = reg_wr_q;
  assign bus.rdata_out = rdata_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: three builds (MEM_LAT 2, 1, 15), each with its own
// latency-pipelined memory, checked cycle by cycle against a transaction model.
module tb_mem_access_ctrl;

  localparam int W = 16;
  localparam int N = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0] start_s, op_we_s;
  logic [W-1:0] addr_s  [N];
  logic [W-1:0] wdata_s [N];
  logic [N-1:0] busy_s, done_s, reg_wr_s, mem_en_s, mem_we_s;
  logic [W-1:0] rdata_s  [N];
  logic [W-1:0] maddr_s  [N];
  logic [W-1:0] mwdata_s [N];

  int checks = 0;
  int errors = 0;

  logic [W-1:0] ref_mem   [N][256];
  logic [W-1:0] exp_rdata [N];
  logic [W-1:0] exp_wdata [N];

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : (k == 1) ? 1 : 15;
  endfunction

  function automatic logic [W-1:0] init_word(input int k, input int i);
    return W'(i * 16'h0101) ^ W'(k * 16'h3C5A) ^ 16'h5A00;
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int L = (g == 0) ? 2 : (g == 1) ? 1 : 15;

    mem_access_ctrl_if #(.WIDTH(W)) bus ();

    mem_access_ctrl #(.WIDTH(W), .MEM_LAT(L)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );

    logic [W-1:0] mem  [256];
    logic [W-1:0] pipe [L];

    initial for (int i = 0; i < 256; i++) mem[i] = init_word(g, i);

    // Read data sits on mem_rdata for exactly one cycle, MEM_LAT edges after
    // the mem_en cycle; every other cycle carries random junk.
    always @(posedge clk) begin
      if (bus.mem_en && bus.mem_we) mem[bus.mem_addr[7:0]] = bus.mem_wdata;
      pipe[0] <= (bus.mem_en && !bus.mem_we) ? mem[bus.mem_addr[7:0]] : W'($urandom);
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end

    assign bus.mem_rdata = pipe[L-1];
    assign bus.start     = start_s[g];
    assign bus.op_we     = op_we_s[g];
    assign bus.addr_in   = addr_s[g];
    assign bus.wdata_in  = wdata_s[g];
    assign busy_s[g]     = bus.busy;
    assign done_s[g]     = bus.done;
    assign reg_wr_s[g]   = bus.reg_wr;
    assign mem_en_s[g]   = bus.mem_en;
    assign mem_we_s[g]   = bus.mem_we;
    assign rdata_s[g]    = bus.rdata_out;
    assign maddr_s[g]    = bus.mem_addr;
    assign mwdata_s[g]   = bus.mem_wdata;
  end

  // Called at a negedge (cycle 0); returns at the negedge of the first idle
  // cycle after DONE, so a following call is a back-to-back request.
  task automatic do_op(input int k, input bit we, input logic [W-1:0] a,
                       input logic [W-1:0] wd, input logic [31:0] rep,
                       input logic [W-1:0] jaddr);
    int t;
    logic [W-1:0] rd_new, ew, er;
    t      = we ? 2 : lat_of(k) + 2;
    rd_new = ref_mem[k][a[7:0]];
    ew     = we ? wd : exp_wdata[k];
    start_s[k] = 1'b1; op_we_s[k] = we; addr_s[k] = a; wdata_s[k] = wd;
    for (int c = 1; c <= t + 1; c++) begin
      @(negedge clk);
      er = (!we && c >= t) ? rd_new : exp_rdata[k];
      checks++;
      if (busy_s[k] !== 1'(c <= t)) begin
        errors++; $display("FAIL busy dut%0d cyc%0d got %b exp %b", k, c, busy_s[k], c <= t);
      end
      checks++;
      if (mem_en_s[k] !== 1'(c == 1)) begin
        errors++; $display("FAIL mem_en dut%0d cyc%0d got %b exp %b", k, c, mem_en_s[k], c == 1);
      end
      if (c == 1) begin
        checks++;
        if (mem_we_s[k] !== we) begin
          errors++; $display("FAIL mem_we dut%0d got %b exp %b", k, mem_we_s[k], we);
        end
      end
      checks++;
      if (maddr_s[k] !== a) begin
        errors++; $display("FAIL mem_addr dut%0d cyc%0d got %h exp %h", k, c, maddr_s[k], a);
      end
      checks++;
      if (mwdata_s[k] !== ew) begin
        errors++; $display("FAIL mem_wdata dut%0d cyc%0d got %h exp %h", k, c, mwdata_s[k], ew);
      end
      checks++;
      if (done_s[k] !== 1'(c == t)) begin
        errors++; $display("FAIL done dut%0d cyc%0d got %b exp %b", k, c, done_s[k], c == t);
      end
      checks++;
      if (reg_wr_s[k] !== 1'(c == t && !we)) begin
        errors++; $display("FAIL reg_wr dut%0d cyc%0d got %b exp %b", k, c, reg_wr_s[k], c == t && !we);
      end
      checks++;
      if (rdata_s[k] !== er) begin
        errors++; $display("FAIL rdata_out dut%0d cyc%0d got %h exp %h", k, c, rdata_s[k], er);
      end
      start_s[k] = (c <= t && c < 32) ? rep[c] : 1'b0;
      op_we_s[k] = 1'($urandom);
      addr_s[k]  = jaddr;
      wdata_s[k] = W'($urandom);
    end
    if (we) begin
      ref_mem[k][a[7:0]] = wd;
      exp_wdata[k] = wd;
    end else begin
      exp_rdata[k] = rd_new;
    end
  endtask

  task automatic check_all_zero(input string tag);
    for (int k = 0; k < N; k++) begin
      checks++;
      if ({busy_s[k], done_s[k], reg_wr_s[k], mem_en_s[k], mem_we_s[k],
           rdata_s[k], maddr_s[k], mwdata_s[k]} !== '0) begin
        errors++;
        $display("FAIL %s dut%0d outputs got %b/%b/%b/%b/%b %h %h %h exp all 0", tag, k,
                 busy_s[k], done_s[k], reg_wr_s[k], mem_en_s[k], mem_we_s[k],
                 rdata_s[k], maddr_s[k], mwdata_s[k]);
      end
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1 check_all_zero("reset_asserted");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_all_zero("reset_idle");
    end
  endtask

  task automatic test_read();
    g_dut[0].mem[8'h42] = 16'hBEEF;
    ref_mem[0][8'h42]   = 16'hBEEF;
    do_op(0, 1'b0, 16'h0042, 16'h0000, 32'd0, 16'h0000);
    checks++;
    if (rdata_s[0] !== 16'hBEEF) begin
      errors++; $display("FAIL read_beef got %h exp %h", rdata_s[0], 16'hBEEF);
    end
  endtask

  task automatic test_write();
    do_op(0, 1'b1, 16'h0010, 16'h1234, 32'd0, 16'h0000);
    do_op(0, 1'b0, 16'h0010, 16'h0000, 32'd0, 16'h0000);
    checks++;
    if (rdata_s[0] !== 16'h1234) begin
      errors++; $display("FAIL write_readback got %h exp %h", rdata_s[0], 16'h1234);
    end
  endtask

  task automatic test_start_ignored();
    do_op(0, 1'b0, 16'h0001, 16'h0000, 32'b10110, 16'h0002);
    do_op(0, 1'b0, 16'h0002, 16'h0000, 32'd0, 16'h0000);
  endtask

  task automatic test_reset_mid();
    start_s[0] = 1'b1; op_we_s[0] = 1'b0; addr_s[0] = 16'h0033;
    @(negedge clk);
    start_s[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (busy_s[0] !== 1'b1) begin
      errors++; $display("FAIL busy_before_reset got %b exp 1", busy_s[0]);
    end
    #2 rst_n = 1'b0;
    #1 check_all_zero("reset_mid");
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < N; k++) begin
      exp_rdata[k] = '0;
      exp_wdata[k] = '0;
    end
    for (int c = 0; c < lat_of(0) + 4; c++) begin
      @(negedge clk);
      checks++;
      if ({done_s[0], reg_wr_s[0], busy_s[0], mem_en_s[0]} !== 4'b0) begin
        errors++;
        $display("FAIL after_reset cyc%0d done/reg_wr/busy/mem_en got %b%b%b%b exp 0000",
                 c, done_s[0], reg_wr_s[0], busy_s[0], mem_en_s[0]);
      end
    end
    do_op(0, 1'b0, 16'h0033, 16'h0000, 32'd0, 16'h0000);
  endtask

  task automatic test_latency();
    for (int k = 0; k < N; k++) begin
      do_op(k, 1'b0, 16'h00FF, 16'h0000, 32'd0, 16'h0000);
      do_op(k, 1'b0, 16'h0100, 16'h0000, 32'd0, 16'h0000);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < N; k++) begin
      for (int n = 0; n < 40; n++) begin
        do_op(k, 1'($urandom), W'($urandom), W'($urandom),
              ($urandom_range(0, 1) == 1) ? $urandom : 32'd0, W'($urandom));
        repeat ($urandom_range(0, 2)) begin
          @(negedge clk);
          checks++;
          if (busy_s[k] !== 1'b0 || done_s[k] !== 1'b0) begin
            errors++; $display("FAIL random_gap dut%0d busy/done got %b%b exp 00", k, busy_s[k], done_s[k]);
          end
        end
      end
    end
  endtask

  initial begin
    start_s = '0;
    op_we_s = '0;
    for (int k = 0; k < N; k++) begin
      addr_s[k]    = '0;
      wdata_s[k]   = '0;
      exp_rdata[k] = '0;
      exp_wdata[k] = '0;
      for (int i = 0; i < 256; i++) ref_mem[k][i] = init_word(k, i);
    end
    test_reset();
    test_read();
    test_write();
    test_start_ignored();
    test_reset_mid();
    test_latency();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Sequenced data-memory access stage for the image sampling processor. It sits directly downstream of the address register's memory-side output (`Mdout`) and upstream of the destination register's write port. On a one-cycle `start` it captures an address, and a write datum when required, from the processor buses. It then runs a single read or write to the synchronous data memory with a fixed latency. Read data is returned with a one-cycle write strobe for the destination register.

## Interface
Parameters:
- `WIDTH`, 16, data and address bus width
- `MEM_LAT`, 2, memory read latency in cycles from the `mem_en` cycle to valid `mem_rdata`; legal range 1..15

Ports:
- `clk`  in  1  processor clock; all state changes on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  request pulse; sampled only in IDLE
- `op_we`  in  1  1 = write, 0 = read; sampled with `start`
- `addr_in`  in  WIDTH  address from the address register's memory bus; sampled with `start`
- `wdata_in`  in  WIDTH  write data from the main data bus; sampled with `start` when `op_we`=1
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle completion pulse
- `reg_wr`  out  1  one-cycle destination-register write strobe; reads only
- `rdata_out`  out  WIDTH  last read datum; held until the next read completes
- `mem_en`  out  1  memory access strobe, one cycle per operation
- `mem_we`  out  1  memory write enable; valid only while `mem_en`=1
- `mem_addr`  out  WIDTH  registered memory address
- `mem_wdata`  out  WIDTH  registered memory write data
- `mem_rdata`  in  WIDTH  memory read data

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - `start`=1 latches `op_we`, `addr_in` into `mem_addr`, and `wdata_in` into `mem_wdata` (writes only; otherwise `mem_wdata` is unchanged), then moves to ISSUE.
  - `start`=0 stays in IDLE.
- ISSUE:
  - `mem_en`=1 and `mem_we`=`op_we` for exactly one cycle.
  - Write: move to DONE.
  - Read: load the latency counter with `MEM_LAT`, then move to WAIT.
- WAIT (reads only):
  - Counter decrements each cycle.
  - On the edge where the counter goes 1→0, register `mem_rdata` into `rdata_out` and move to DONE.
- DONE:
  - `done`=1 for one cycle; `reg_wr`=1 only if the operation was a read.
  - Always return to IDLE; `start` in this cycle is ignored.
- `start` in ISSUE, WAIT or DONE is ignored and not queued.
- X or Z on `addr_in`/`wdata_in` is captured as-is. The upstream register must drive its bus (`rM`/`rR` high) in the `start` cycle.
- Reset, including mid-operation:
  - State returns to IDLE immediately (asynchronous), and the counter clears.
  - `busy`, `done`, `reg_wr`, `mem_en`, `mem_we` = 0.
  - `mem_addr`, `mem_wdata`, `rdata_out` = 0.
  - Any in-flight read is discarded.

## Timing
- Cycle 0 = the cycle in which `start` is sampled high in IDLE.
- Read:
  - `mem_en` high in cycle 1.
  - WAIT occupies cycles 2..MEM_LAT+1.
  - `done`/`reg_wr` high in cycle MEM_LAT+2, with `rdata_out` already valid.
  - Next `start` can be accepted in cycle MEM_LAT+3.
- Write:
  - `mem_en`/`mem_we` high in cycle 1.
  - `done` high in cycle 2; `reg_wr` stays 0.
  - Next `start` can be accepted in cycle 3.
- `busy` rises in cycle 1 and falls after the DONE cycle.
- All outputs are registered; no combinational path runs from any input to any output.
- `mem_rdata` must be stable on the edge ending the last WAIT cycle. That edge corresponds to MEM_LAT edges after the `mem_en` cycle.

## Structure
- Shared package `mem_ctrl_pkg`:
  - 2-bit state encodings: IDLE=00, ISSUE=01, WAIT=10, DONE=11.
  - `OP_READ`=0, `OP_WRITE`=1.
  - Latency counter width = 4.
- Sub-module `lat_counter`:
  - Ports: `clk`, `rst_n`, `load`, `val[3:0]`.
  - Output: `zero_next`, asserted when the count equals 1.
  - Instantiated once.
- The rest is a single FSM plus datapath registers in `mem_access_ctrl`.

## Test plan
- Reset release, then idle for 5 cycles -> all outputs 0 and `busy`=0 throughout.
- Read, `MEM_LAT`=2: `addr_in`=0x0042; the memory model returns 0xBEEF two cycles after `mem_en` -> `mem_en`=1, `mem_we`=0, `mem_addr`=0x0042 in cycle 1; `done`=`reg_wr`=1 in cycle 4; `rdata_out`=0xBEEF.
- Write: `addr_in`=0x0010, `wdata_in`=0x1234 -> `mem_en`=`mem_we`=1, `mem_addr`=0x0010, `mem_wdata`=0x1234 in cycle 1; `done`=1 and `reg_wr`=0 in cycle 2; `rdata_out` unchanged.
- Read 0x0001 with `start` re-pulsed in cycles 1, 2 and 4 (addr 0x0002) -> exactly one `mem_en`, at 0x0001; a second read issues only after `start` is held in cycle 5.
- `rst_n` driven low during WAIT of a read -> outputs drop to 0 asynchronously; no `done` or `reg_wr` after release; the next read completes normally with `MEM_LAT`+2 latency.
- `MEM_LAT`=1 and `MEM_LAT`=15 builds, back-to-back reads to 0x00FF then 0x0100 -> `done` at cycles 3/15+2 relative to each start; `rdata_out` matches each memory word in order.
